mem_wb_data_input_mux: RTL and testbench
========================================

Name: mem_wb_data_input_mux

Overview:
- Data-select block of the memory pipeline stage.
- Chooses which byte pair is written into the MEM/WB data path:
  - the value carried from EX/MEM (ALU result or store data), or
  - the load result returned by the memory I/O unit, or
  - a mix of the two byte lanes.
- Output is registered on the rising clock edge, so it forms the data half of the MEM/WB boundary.

Parameters:
- DATA_WIDTH, 8, width of each byte lane (top and bot).

Ports:
- clock  input  1  stage clock; all state updates on its rising edge.
- nreset  input  1  asynchronous active-low reset.
- sel_signals  input  2  source select, encoding below.
- mem_data_top  input  DATA_WIDTH  upper lane from EX/MEM.
- mem_data_bot  input  DATA_WIDTH  lower lane from EX/MEM.
- ld_res_top  input  DATA_WIDTH  upper lane of the memory read result.
- ld_res_bot  input  DATA_WIDTH  lower lane of the memory read result.
- mem_data_out_top  output  DATA_WIDTH  registered upper lane to MEM/WB.
- mem_data_out_bot  output  DATA_WIDTH  registered lower lane to MEM/WB.

Behaviour:
- Reset:
  - nreset low forces both outputs to 0 immediately, independent of clock.
  - Outputs hold 0 while nreset is low.
  - Deassertion is taken synchronously by design convention; the first capture is on the first rising edge with nreset high.
- Select encoding, applied per lane:
  - 2'b00 PASS: top <- mem_data_top, bot <- mem_data_bot.
  - 2'b01 LOAD: top <- ld_res_top, bot <- ld_res_bot.
  - 2'b10 LOAD_LO: top <- mem_data_top, bot <- ld_res_bot (byte load into low lane, upper lane preserved).
  - 2'b11 LOAD_HI: top <- ld_res_top, bot <- mem_data_bot (byte load into high lane, lower lane preserved).
- Latency:
  - Exactly one cycle. Inputs and select sampled at rising edge N appear on the outputs after edge N.
  - Outputs are stable for the whole of the following cycle.
- Every rising edge with nreset high captures. There is no enable and no stall; stall handling belongs to the surrounding pipeline registers.
- No combinational path from any input to any output.
- Select changes take effect at the next edge, with no glitch on the outputs.
- The two lanes are fully independent: no sign/zero extension, no arithmetic, no carry between lanes.
- X on an unselected lane must not propagate to the outputs.
- Reset asserted mid-operation: outputs clear at once, and the pending capture is discarded.
- Reset and clock edge together: reset wins and outputs stay 0.

Decomposition:
- Shared package (pipeline constants) holds:
  - the 2-bit select localparams MEMWB_SEL_PASS=0, MEMWB_SEL_LOAD=1, MEMWB_SEL_LOAD_LO=2, MEMWB_SEL_LOAD_HI=3;
  - the DATA_WIDTH default.
- The control decoder and this block use the same constants.
- One natural sub-module: byte_lane_mux, a 2:1 combinational lane select instantiated once per lane. The lane select bit is derived from sel_signals per the encoding above.
- The output register stays in the top module.

Test Plan:
- Reset: nreset=0 with inputs 8'hAA/8'h55 and several clock edges -> outputs 0x00/0x00. Pulse nreset low asynchronously between edges -> outputs drop to 0 before the next edge.
- PASS: sel=00, mem_data=0x12/0x34, ld_res=0xAB/0xCD -> after one edge, out=0x12/0x34.
- LOAD: sel=01 with the same inputs -> out=0xAB/0xCD one cycle later; previous value held until that edge.
- Mixed lanes:
  - sel=10 -> out=0x12/0xCD.
  - sel=11 -> out=0xAB/0x34.
  - Cycle sel 00,01,10,11 on consecutive edges -> outputs follow one cycle behind each select.
- Latency: change inputs and select between edges -> outputs unchanged until the next rising edge.
- Reset mid-stream: sel=01 with ld_res=0xFF/0xFF, then assert nreset just before an edge -> outputs 0 that cycle. After release, the next edge loads 0xFF/0xFF.

Source files
------------

// File: rtl/mem_wb_data_input_mux_pkg.sv
// mem_wb_data_input_mux_pkg: pipeline constants shared by the MEM/WB data select and the control decoder
package mem_wb_data_input_mux_pkg;
  localparam int DATA_WIDTH = 8;
  localparam logic [1:0] MEMWB_SEL_PASS    = 2'd0;
  localparam logic [1:0] MEMWB_SEL_LOAD    = 2'd1;
  localparam logic [1:0] MEMWB_SEL_LOAD_LO = 2'd2;
  localparam logic [1:0] MEMWB_SEL_LOAD_HI = 2'd3;
  function automatic logic top_from_load(input logic [1:0] sel);
    return sel == MEMWB_SEL_LOAD || sel == MEMWB_SEL_LOAD_HI;
  endfunction
  function automatic logic bot_from_load(input logic [1:0] sel);
    return sel == MEMWB_SEL_LOAD || sel == MEMWB_SEL_LOAD_LO;
  endfunction
endpackage

// File: rtl/mem_wb_data_input_mux_byte_lane_mux.sv
// byte_lane_mux: 2:1 combinational select for one byte lane
module byte_lane_mux #(
  parameter int W = 8
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  always_comb y = sel ? b : a;
endmodule

// File: rtl/mem_wb_data_input_mux.sv
// mem_wb_data_input_mux: registered per-lane choice between EX/MEM data and load result
module mem_wb_data_input_mux
  import mem_wb_data_input_mux_pkg::*;
#(
  parameter int DATA_WIDTH = mem_wb_data_input_mux_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [1:0]            sel_signals,
  input  logic [DATA_WIDTH-1:0] mem_data_top,
  input  logic [DATA_WIDTH-1:0] mem_data_bot,
  input  logic [DATA_WIDTH-1:0] ld_res_top,
  input  logic [DATA_WIDTH-1:0] ld_res_bot,
  output logic [DATA_WIDTH-1:0] mem_data_out_top,
  output logic [DATA_WIDTH-1:0] mem_data_out_bot
);
  logic [DATA_WIDTH-1:0] top_next, bot_next;
  byte_lane_mux #(.W(DATA_WIDTH)) u_top (
    .sel(top_from_load(sel_signals)),
    .a(mem_data_top),
    .b(ld_res_top),
    .y(top_next)
  );
  byte_lane_mux #(.W(DATA_WIDTH)) u_bot (
    .sel(bot_from_load(sel_signals)),
    .a(mem_data_bot),
    .b(ld_res_bot),
    .y(bot_next)
  );
  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      mem_data_out_top <= '0;
      mem_data_out_bot <= '0;
    end else begin
      mem_data_out_top <= top_next;
      mem_data_out_bot <= bot_next;
    end
endmodule

// File: tb/tb_mem_wb_data_input_mux.sv
// tb_mem_wb_data_input_mux: randomized and directed checks against a lane-selection model
module tb_mem_wb_data_input_mux;
  logic clock = 1'b0;
  logic nreset;
  logic [1:0] sel_signals;
  logic [7:0] mem_data_top, mem_data_bot, ld_res_top, ld_res_bot;
  logic [7:0] mem_data_out_top, mem_data_out_bot;
  int total = 0;
  int passed = 0;

  mem_wb_data_input_mux dut (
    .clock(clock),
    .nreset(nreset),
    .sel_signals(sel_signals),
    .mem_data_top(mem_data_top),
    .mem_data_bot(mem_data_bot),
    .ld_res_top(ld_res_top),
    .ld_res_bot(ld_res_bot),
    .mem_data_out_top(mem_data_out_top),
    .mem_data_out_bot(mem_data_out_bot)
  );

  always #5 clock = ~clock;

  // Reference: select code chooses which source feeds each lane.
  function automatic logic [15:0] model(input logic [1:0] s, input logic [7:0] mt, mb, lt, lb);
    case (s)
      2'b00: return {mt, mb};
      2'b01: return {lt, lb};
      2'b10: return {mt, lb};
      default: return {lt, mb};
    endcase
  endfunction

  task automatic drive(input logic [1:0] s, input logic [7:0] mt, mb, lt, lb);
    sel_signals = s;
    mem_data_top = mt;
    mem_data_bot = mb;
    ld_res_top = lt;
    ld_res_bot = lb;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    nreset = 1'b0;
    drive(2'b00, 8'hAA, 8'h55, 8'hAA, 8'h55);
    repeat (3) step();
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'h0000)
      $display("FAIL reset_hold got=%h want=0000", {mem_data_out_top, mem_data_out_bot});
    else passed++;
    @(negedge clock);
    nreset = 1'b1;
    step();
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'hAA55)
      $display("FAIL reset_release got=%h want=aa55", {mem_data_out_top, mem_data_out_bot});
    else passed++;
    @(negedge clock);
    nreset = 1'b0;
    #1;
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'h0000)
      $display("FAIL reset_async got=%h want=0000", {mem_data_out_top, mem_data_out_bot});
    else passed++;
    #1 nreset = 1'b1;
  endtask

  task automatic test_sel(input string name, input logic [1:0] s, input logic [15:0] want);
    @(negedge clock);
    drive(s, 8'h12, 8'h34, 8'hAB, 8'hCD);
    step();
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== want)
      $display("FAIL %s got=%h want=%h", name, {mem_data_out_top, mem_data_out_bot}, want);
    else passed++;
  endtask

  task automatic test_load_holds();
    test_sel("pass", 2'b00, 16'h1234);
    @(negedge clock);
    sel_signals = 2'b01;
    #2;
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'h1234)
      $display("FAIL load_hold got=%h want=1234", {mem_data_out_top, mem_data_out_bot});
    else passed++;
    step();
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'hABCD)
      $display("FAIL load got=%h want=abcd", {mem_data_out_top, mem_data_out_bot});
    else passed++;
  endtask

  task automatic test_cycle();
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [15:0] want [4] = '{16'h1234, 16'hABCD, 16'h12CD, 16'hAB34};
    @(negedge clock);
    drive(2'b00, 8'h12, 8'h34, 8'hAB, 8'hCD);
    for (int i = 0; i < 4; i++) begin
      sel_signals = seq[i];
      @(posedge clock);
      #1;
      total++;
      if ({mem_data_out_top, mem_data_out_bot} !== want[i])
        $display("FAIL cycle_%0d got=%h want=%h", i, {mem_data_out_top, mem_data_out_bot}, want[i]);
      else passed++;
    end
  endtask

  task automatic test_x_unselected();
    @(negedge clock);
    drive(2'b00, 8'h5A, 8'hA5, 8'hxx, 8'hxx);
    step();
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'h5AA5)
      $display("FAIL x_pass got=%h want=5aa5", {mem_data_out_top, mem_data_out_bot});
    else passed++;
    @(negedge clock);
    drive(2'b10, 8'h3C, 8'hxx, 8'hxx, 8'hC3);
    step();
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'h3CC3)
      $display("FAIL x_load_lo got=%h want=3cc3", {mem_data_out_top, mem_data_out_bot});
    else passed++;
  endtask

  task automatic test_latency();
    logic [15:0] prev;
    test_sel("lat_setup", 2'b11, 16'hAB34);
    prev = {mem_data_out_top, mem_data_out_bot};
    @(negedge clock);
    drive(2'b01, 8'h99, 8'h88, 8'h77, 8'h66);
    #3;
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== prev)
      $display("FAIL latency_hold got=%h want=%h", {mem_data_out_top, mem_data_out_bot}, prev);
    else passed++;
    step();
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'h7766)
      $display("FAIL latency_capture got=%h want=7766", {mem_data_out_top, mem_data_out_bot});
    else passed++;
  endtask

  task automatic test_reset_mid();
    test_sel("mid_setup", 2'b00, 16'h1234);
    @(negedge clock);
    drive(2'b01, 8'h00, 8'h00, 8'hFF, 8'hFF);
    #4;
    nreset = 1'b0;
    #0.5;
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'h0000)
      $display("FAIL mid_reset_now got=%h want=0000", {mem_data_out_top, mem_data_out_bot});
    else passed++;
    step();
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'h0000)
      $display("FAIL mid_reset_edge got=%h want=0000", {mem_data_out_top, mem_data_out_bot});
    else passed++;
    @(negedge clock);
    nreset = 1'b1;
    step();
    total++;
    if ({mem_data_out_top, mem_data_out_bot} !== 16'hFFFF)
      $display("FAIL mid_reset_release got=%h want=ffff", {mem_data_out_top, mem_data_out_bot});
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] want;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      drive(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      want = model(sel_signals, mem_data_top, mem_data_bot, ld_res_top, ld_res_bot);
      step();
      total++;
      if ({mem_data_out_top, mem_data_out_bot} !== want)
        $display("FAIL random_%0d sel=%b got=%h want=%h", i, sel_signals, {mem_data_out_top, mem_data_out_bot}, want);
      else passed++;
    end
  endtask

  initial begin
    nreset = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_sel("pass", 2'b00, 16'h1234);
    test_load_holds();
    test_sel("load_lo", 2'b10, 16'h12CD);
    test_sel("load_hi", 2'b11, 16'hAB34);
    test_cycle();
    test_x_unselected();
    test_latency();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
